// File: rtl/seg_disp_sched.sv
// seg_disp_sched: shares a 4-digit multiplexed seven-segment display between two
// 16-bit requesters. It generates the digit scan timing and re-arbitrates ownership
// round-robin, but only at frame boundaries, so a digit never shows a mix of sources.
// The owner's data is snapshotted once per frame for the downstream decoder.
module seg_disp_sched #(
    parameter int CLK_DIV     = 1000,  // clock cycles per digit slot (>=2)
    parameter int HOLD_FRAMES = 4      // minimum owned frames when contended (>=1)
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [1:0]  i_req,
    input  logic [15:0] i_data0,
    input  logic [15:0] i_data1,
    output logic [1:0]  o_gnt,
    output logic [15:0] o_data,
    output logic [1:0]  o_digit_sel,
    output logic [3:0]  o_an,
    output logic        o_frame_done
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_FRAMES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    logic [PW-1:0] presc_reg, presc_next;
    logic [1:0]    digit_reg, digit_next;
    state_t        state_reg, state_next;
    logic [15:0]   data_reg, data_next;
    logic [3:0]    an_reg, an_next;
    logic [HW-1:0] hold_reg, hold_next;
    logic          last_reg, last_next;   // 0 = src0 owned last, 1 = src1

    logic          tick;
    logic          boundary;
    logic [3:0]    an_dec;

    // Arbitration decision helpers
    logic          grant_en;
    logic          grant_sel;
    logic          stay_en;
    logic          cur_src;

    assign tick     = (presc_reg == PRESC_MAX);
    assign boundary = tick && (digit_reg == 2'd3);

    // Scan timing: prescaler wraps every slot, digit advances on each slot tick
    always_comb begin
        presc_next = tick ? '0 : presc_reg + 1'b1;
        digit_next = tick ? digit_reg + 2'd1 : digit_reg;
    end

    // One-hot-low anode pattern for the digit that will be shown after this edge
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_an_dec
            assign an_dec[gi] = (digit_next != 2'(gi));
        end
    endgenerate

    // Arbitration FSM: only acts on the frame-boundary cycle
    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        hold_next  = hold_reg;
        last_next  = last_reg;
        grant_en   = 1'b0;
        grant_sel  = 1'b0;
        stay_en    = 1'b0;
        cur_src    = (state_reg == ST_OWN1);

        if (boundary) begin
            case (state_reg)
                ST_IDLE: begin
                    if (i_req == 2'b11) begin
                        grant_en  = 1'b1;
                        grant_sel = ~last_reg;
                    end else if (i_req[0]) begin
                        grant_en  = 1'b1;
                        grant_sel = 1'b0;
                    end else if (i_req[1]) begin
                        grant_en  = 1'b1;
                        grant_sel = 1'b1;
                    end
                end
                ST_OWN0, ST_OWN1: begin
                    if (i_req[cur_src]) begin
                        // Contended owner yields only once its hold window completes
                        if (i_req[~cur_src] && (hold_reg >= HOLD_LAST)) begin
                            grant_en  = 1'b1;
                            grant_sel = ~cur_src;
                        end else begin
                            stay_en = 1'b1;
                        end
                    end else if (i_req[~cur_src]) begin
                        // Owner released: hand over immediately, hold is irrelevant
                        grant_en  = 1'b1;
                        grant_sel = ~cur_src;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase

            if (grant_en) begin
                state_next = grant_sel ? ST_OWN1 : ST_OWN0;
                data_next  = grant_sel ? i_data1 : i_data0;
                hold_next  = '0;
                last_next  = grant_sel;
            end else if (stay_en) begin
                data_next = cur_src ? i_data1 : i_data0;
                hold_next = (hold_reg == HOLD_MAX) ? hold_reg : hold_reg + 1'b1;
            end
        end

        an_next = (state_next == ST_IDLE) ? 4'b1111 : an_dec;
    end

    // State register for scan timing, ownership and the frame snapshot
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            presc_reg <= '0;
            digit_reg <= 2'd0;
            state_reg <= ST_IDLE;
            data_reg  <= 16'h0000;
            an_reg    <= 4'b1111;
            hold_reg  <= '0;
            last_reg  <= 1'b1;  // src0 wins the first tie
        end else begin
            presc_reg <= presc_next;
            digit_reg <= digit_next;
            state_reg <= state_next;
            data_reg  <= data_next;
            an_reg    <= an_next;
            hold_reg  <= hold_next;
            last_reg  <= last_next;
        end
    end

    assign o_gnt        = {state_reg == ST_OWN1, state_reg == ST_OWN0};
    assign o_data       = data_reg;
    assign o_digit_sel  = digit_reg;
    assign o_an         = an_reg;
    assign o_frame_done = boundary;

endmodule

// File: tb/tb_seg_disp_sched.sv
// tb_seg_disp_sched: directed scenarios plus random traffic, every cycle compared
// against a frame-level reference model of the display scheduler.
module tb_seg_disp_sched;

    localparam int CD  = 4;
    localparam int HF  = 2;
    localparam int FRM = 4 * CD;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [1:0]  i_req;
    logic [15:0] i_data0;
    logic [15:0] i_data1;
    logic [1:0]  o_gnt;
    logic [15:0] o_data;
    logic [1:0]  o_digit_sel;
    logic [3:0]  o_an;
    logic        o_frame_done;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: time since reset, owner (-1 idle), frames owned, last owner
    int          m_t;
    int          m_owner;
    int          m_frames;
    int          m_last;
    logic [15:0] m_data;

    seg_disp_sched #(.CLK_DIV(CD), .HOLD_FRAMES(HF)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req       (i_req),
        .i_data0     (i_data0),
        .i_data1     (i_data1),
        .o_gnt       (o_gnt),
        .o_data      (o_data),
        .o_digit_sel (o_digit_sel),
        .o_an        (o_an),
        .o_frame_done(o_frame_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0d got=%0h exp=%0h", tag, m_t, got, exp);
        end
    endtask

    // Advance the reference model by one clock edge with the given inputs
    task automatic model_edge(input logic rst, input logic [1:0] req,
                              input logic [15:0] d0, input logic [15:0] d1);
        int nxt;
        int oth;
        if (rst) begin
            m_t = 0; m_owner = -1; m_frames = 0; m_last = 1; m_data = 16'h0;
        end else begin
            if (m_t % FRM == FRM - 1) begin
                nxt = m_owner;
                if (m_owner < 0) begin
                    if (req == 2'b11)  nxt = 1 - m_last;
                    else if (req[0])   nxt = 0;
                    else if (req[1])   nxt = 1;
                end else begin
                    oth = 1 - m_owner;
                    if (req[m_owner]) begin
                        if (req[oth] && (m_frames + 1 >= HF)) nxt = oth;
                    end else if (req[oth]) begin
                        nxt = oth;
                    end else begin
                        nxt = -1;
                    end
                end
                if (nxt >= 0) begin
                    if (nxt != m_owner) begin
                        m_frames = 0;
                        m_last   = nxt;
                    end else begin
                        m_frames++;
                    end
                    m_data = (nxt == 1) ? d1 : d0;
                end
                m_owner = nxt;
            end
            m_t++;
        end
    endtask

    // Drive one cycle, step the model, then compare all outputs after the edge
    task automatic step(input logic rst, input logic [1:0] req,
                        input logic [15:0] d0, input logic [15:0] d1);
        int dig;
        i_rst = rst; i_req = req; i_data0 = d0; i_data1 = d1;
        model_edge(rst, req, d0, d1);
        @(posedge i_clk);
        #1;
        dig = (m_t / CD) % 4;
        check("gnt",   32'(o_gnt),  (m_owner < 0) ? 32'd0 : 32'(1 << m_owner));
        check("data",  32'(o_data), 32'(m_data));
        check("digit", 32'(o_digit_sel), 32'(dig));
        check("an",    32'(o_an),   (m_owner < 0) ? 32'hF : 32'(~(4'b0001 << dig) & 4'hF));
        check("frame_done", 32'(o_frame_done), 32'(m_t % FRM == FRM - 1));
        $display("cyc t=%0d rst=%0b req=%02b gnt=%02b an=%04b data=%04h fd=%0b",
                 m_t, rst, req, o_gnt, o_an, o_data, o_frame_done);
    endtask

    task automatic run(input int n, input logic rst, input logic [1:0] req,
                       input logic [15:0] d0, input logic [15:0] d1);
        for (int k = 0; k < n; k++) step(rst, req, d0, d1);
    endtask

    initial begin
        logic [1:0]  r_req;
        logic [15:0] r_d0;
        logic [15:0] r_d1;
        logic        r_rst;

        i_rst = 1'b1; i_req = 2'b00; i_data0 = 16'h0; i_data1 = 16'h0;
        m_t = 0; m_owner = -1; m_frames = 0; m_last = 1; m_data = 16'h0;

        // Reset and idle scanning
        run(3, 1'b1, 2'b00, 16'h0, 16'h0);
        check("rst_an",   32'(o_an),   32'hF);
        check("rst_gnt",  32'(o_gnt),  32'h0);
        check("rst_data", 32'(o_data), 32'h0);
        run(34, 1'b0, 2'b00, 16'h0, 16'h0);

        // Single requester, then a mid-frame data change
        run(30, 1'b0, 2'b01, 16'h0146, 16'h0);
        check("own0_gnt",  32'(o_gnt),  32'h1);
        check("own0_data", 32'(o_data), 32'h0146);
        run(5, 1'b0, 2'b01, 16'h0146, 16'h0);
        run(40, 1'b0, 2'b01, 16'h4166, 16'h0);

        // Contention from idle: alternate every two frames
        run(1, 1'b1, 2'b00, 16'h0, 16'h0);
        run(100, 1'b0, 2'b11, 16'h0146, 16'h235E);

        // Owner drops request with and without a waiting peer
        run(40, 1'b0, 2'b01, 16'h0146, 16'h235E);
        run(20, 1'b0, 2'b00, 16'h1111, 16'h2222);
        run(20, 1'b0, 2'b01, 16'h0146, 16'h235E);
        run(20, 1'b0, 2'b10, 16'h0146, 16'h235E);
        check("switch_gnt", 32'(o_gnt), 32'h2);

        // Reset mid-frame while src1 owns, then tie goes to src0
        run(7, 1'b0, 2'b10, 16'h0146, 16'h235E);
        run(1, 1'b1, 2'b10, 16'h0146, 16'h235E);
        run(20, 1'b0, 2'b11, 16'h0146, 16'h235E);
        check("tie_gnt", 32'(o_gnt), 32'h1);

        // Random traffic
        r_req = 2'b00; r_d0 = 16'h0; r_d1 = 16'h0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(19) == 0) r_req = 2'($urandom);
            if ($urandom_range(3) == 0)  r_d0  = 16'($urandom);
            if ($urandom_range(3) == 0)  r_d1  = 16'($urandom);
            r_rst = ($urandom_range(499) == 0);
            step(r_rst, r_req, r_d0, r_d1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
